encoder_pri_rr: RTL

Parametrised successor to the team's fixed 4-to-2 one-hot encoder. Samples an N-bit request vector under a valid/ready handshake and selects one set bit. The selection rule is strict one-hot, fixed priority or round-robin. Returns the binary index plus hit/err flags from a one-entry registered output stage. Sits between request sources (interrupt lines, arbitration requests) and a consumer that may stall.

---
 rtl/encoder_pri_rr_pkg.sv | 16 +
 rtl/encoder_pri_rr_find_first.sv | 33 +++
 rtl/encoder_pri_rr.sv | 94 +++++++++
 3 files changed

// File: rtl/encoder_pri_rr_pkg.sv
// Shared mode constants, counter width and the multi-hot test used by
// encoder_pri_rr and its find-first helper.
package enc_pkg;

  localparam int ENC_MODE_STRICT = 0;
  localparam int ENC_MODE_PRIO   = 1;
  localparam int ENC_MODE_RR     = 2;

  localparam int ENC_CNT_W = 16;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic enc_multi_hot(input logic [255:0] v);
    return (v & (v - 256'(1))) != '0;
  endfunction

endpackage

// File: rtl/encoder_pri_rr_find_first.sv
// Combinational wrapped search: first set bit of vec at or above start,
// wrapping from N-1 back to 0.
module enc_find_first #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // One extra bit holds start+offset (< 2N) before the explicit wrap.
  logic [W:0]   sum;
  logic [W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned o = 0; o < N; o++) begin
      sum = {1'b0, start} + (W+1)'(o);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      cand = sum[W-1:0];
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/encoder_pri_rr.sv
// N-input encoder (strict one-hot / fixed priority / round-robin) with a
// one-entry registered output stage. ENC_ERRCNT_EN adds a saturating err_cnt.
module encoder_pri_rr
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = ENC_MODE_STRICT,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         hit,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
`ifdef ENC_ERRCNT_EN
  ,
  output logic [ENC_CNT_W-1:0] err_cnt
`endif
);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] ff_idx;
  logic         ff_found;
  logic         accept;
  logic         multi;
  logic [W-1:0] nxt_out;
  logic         nxt_hit;
  logic         nxt_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign multi    = enc_multi_hot(256'(in));
  assign start    = (MODE == ENC_MODE_RR) ? ptr : '0;

  enc_find_first #(.N(N)) u_find (
    .vec   (in),
    .start (start),
    .idx   (ff_idx),
    .found (ff_found)
  );

  always_comb begin
    nxt_out = ff_idx;
    nxt_hit = ff_found;
    nxt_err = 1'b0;
    if (MODE == ENC_MODE_STRICT) begin
      nxt_hit = ff_found && !multi;
      nxt_err = multi;
      nxt_out = nxt_hit ? ff_idx : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      hit       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= nxt_out;
      hit       <= nxt_hit;
      err       <= nxt_err;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Wrap at N-1 is explicit so non-power-of-two N never lands on an idle index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == ENC_MODE_RR && accept && ff_found) begin
      ptr <= (ff_idx == W'(N-1)) ? '0 : ff_idx + 1'b1;
    end
  end

`ifdef ENC_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && multi && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
